// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//
// Receives a program as a byte stream and writes it into the core's
// instruction memory. It holds the core in reset until a complete, valid
// program has been written. This lets the core be reprogrammed at run time
// instead of relying on a static memory preload.
//
// Stream format: one header byte carrying the word count N (1..DEPTH),
// followed by 4*N data bytes. Each word is sent MSB first.
//
// Ports
//   clk        in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   load_start in   single-cycle request to begin a load (IDLE/DONE/ERR only)
//   in_valid   in   byte-stream valid
//   in_data    in   byte-stream data (sampled only when accepted)
//   in_ready   out  byte-stream ready (high in HDR and DATA)
//   mem_we     out  instruction-memory write enable, one-cycle pulse
//   mem_waddr  out  instruction-memory write address
//   mem_wdata  out  instruction word to write
//   cpu_rst    out  active-high reset to the core
//   busy       out  a load is in progress
//   done       out  last load completed successfully
//   err        out  last load aborted (bad header or timeout)
// ----------------------------------------------------------------------------
module prog_loader #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   input  logic          load_start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   // The idle counter only needs to reach TIMEOUT-1. When the timeout is
   // disabled, a 1-bit counter is kept so that the code stays uniform.
   localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]   TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [8:0]      DEPTH_9 = 9'(DEPTH);

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   logic [2:0]    r_state;
   logic          r_in_ready;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_waddr;
   logic [31:0]   r_mem_wdata;
   logic          r_cpu_rst;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   // Load bookkeeping
   logic [AW-1:0] r_last_idx;   // N-1, index of the final word
   logic [AW-1:0] r_word_idx;
   logic [1:0]    r_byte_idx;
   logic [23:0]   r_asm;        // first three bytes of the word being built
   logic [CW-1:0] r_idle_cnt;

   logic          w_accept;
   logic          w_loading;
   logic          w_start;
   logic          w_hdr_bad;
   logic          w_timeout;
   logic          w_to_err;
   logic          w_word_end;
   logic          w_last_word;

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_waddr = r_mem_waddr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_rst   = r_cpu_rst;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

   // r_in_ready is high exactly in HDR and DATA. It therefore doubles as the
   // state qualifier for the handshake.
   assign w_accept    = in_valid & r_in_ready;
   assign w_loading   = (r_state == ST_HDR) || (r_state == ST_DATA);

   // load_start is honoured only when no load is running.
   assign w_start     = load_start &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

   assign w_hdr_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_9);

   // The counter shows the number of idle edges already seen. The edge that
   // would make it equal TIMEOUT is the edge that aborts the load.
   assign w_timeout   = (TIMEOUT != 0) && (r_idle_cnt == TO_LAST);

   assign w_to_err    = ((r_state == ST_HDR) && w_accept && w_hdr_bad) ||
                        (w_loading && !w_accept && w_timeout);

   assign w_word_end  = (r_byte_idx == 2'd3);
   assign w_last_word = (r_word_idx == r_last_idx);

   // ---------------------------------------------------------------------
   // Control FSM, counters and write port
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_cpu_rst   <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_last_idx  <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_asm       <= '0;
         r_idle_cnt  <= '0;
      end else begin
         // The write enable is a single-cycle pulse unless it is re-armed below.
         r_mem_we <= 1'b0;

         if (w_start) begin
            r_state    <= ST_HDR;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_idle_cnt <= '0;
         end else if (w_to_err) begin
            r_state    <= ST_ERR;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_cpu_rst  <= 1'b1;
            r_idle_cnt <= '0;
         end else begin
            case (r_state)
               ST_HDR: begin
                  if (w_accept) begin
                     r_idle_cnt <= '0;
                     r_last_idx <= AW'(in_data - 8'd1);
                     r_word_idx <= '0;
                     r_byte_idx <= '0;
                     r_state    <= ST_DATA;
                  end else if (TIMEOUT != 0) begin
                     r_idle_cnt <= r_idle_cnt + CW'(1);
                  end
               end

               ST_DATA: begin
                  if (w_accept) begin
                     r_idle_cnt <= '0;
                     r_byte_idx <= r_byte_idx + 2'd1;
                     if (w_word_end) begin
                        r_mem_wdata <= {r_asm, in_data};
                        r_mem_waddr <= r_word_idx;
                        r_mem_we    <= 1'b1;
                        r_word_idx  <= r_word_idx + AW'(1);
                        if (w_last_word) begin
                           // The final write pulse coincides with the first
                           // DONE cycle. The core is released one cycle later.
                           r_state    <= ST_DONE;
                           r_in_ready <= 1'b0;
                           r_busy     <= 1'b0;
                           r_done     <= 1'b1;
                        end
                     end else begin
                        r_asm <= {r_asm[15:0], in_data};
                     end
                  end else if (TIMEOUT != 0) begin
                     r_idle_cnt <= r_idle_cnt + CW'(1);
                  end
               end

               ST_DONE: begin
                  // Falls on the edge that ends the last write pulse.
                  r_cpu_rst <= 1'b0;
               end

               ST_ERR: begin
                  r_cpu_rst <= 1'b1;
               end

               default: begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int TIMEOUT = 8;

   logic          clk;
   logic          sys_rst_n;
   logic          load_start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;

   prog_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic [7:0] hdr;
      int         stall;
      logic [7:0] seed;
      bit         ok;     // 1: expect done, 0: expect err
   } vec_t;

   wr_t  sb_q[$];
   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write scoreboard: every mem_we pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data %h, no write expected", mem_waddr, mem_wdata);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            check("write_addr", 32'(mem_waddr), 32'(e.addr));
            check("write_data", mem_wdata, e.data);
         end
      end
   end

   function automatic logic [31:0] word_of(input logic [7:0] seed, input int i);
      logic [7:0] ib;
      ib = 8'(i);
      if (seed == 8'd0) return (i == 0) ? 32'h08400005 : 32'h10420003;
      return {seed, ib, ~seed, ib ^ 8'h5A};
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int k;
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept_timeout: in_ready %b expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("hdr_busy", 32'(busy), 32'd1);
      check("hdr_cpu_rst", 32'(cpu_rst), 32'd1);
      check("hdr_done", 32'(done), 32'd0);
      check("hdr_err", 32'(err), 32'd0);
      check("hdr_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic do_load(input vec_t v);
      logic [31:0] wd;
      pulse_start();
      send_byte(v.hdr);
      if (!v.ok) begin
         check("bad_err", 32'(err), 32'd1);
         check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
         check("bad_busy", 32'(busy), 32'd0);
         check("bad_in_ready", 32'(in_ready), 32'd0);
         in_valid = 1'b1;
         in_data  = 8'hFF;
         repeat (4) @(negedge clk);
         check("bad_in_ready_later", 32'(in_ready), 32'd0);
         check("bad_err_later", 32'(err), 32'd1);
         in_valid = 1'b0;
         return;
      end
      for (int w = 0; w < int'(v.hdr); w++) begin
         wd = word_of(v.seed, w);
         for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < v.stall; s++) begin
               in_data = 8'($urandom);
               @(negedge clk);
            end
            if (b == 3) sb_q.push_back('{addr: AW'(w), data: wd});
            send_byte(wd[31-8*b -: 8]);
         end
      end
      check("last_we_pulse", 32'(mem_we), 32'd1);
      check("cpu_rst_on_last_we", 32'(cpu_rst), 32'd1);
      check("done_on_last_we", 32'(done), 32'd1);
      @(negedge clk);
      check("done_cpu_rst", 32'(cpu_rst), 32'd0);
      check("done_done", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_err", 32'(err), 32'd0);
      check("done_sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vecs[0] = '{hdr: 8'd2,  stall: 0, seed: 8'h00, ok: 1'b1};
      vecs[1] = '{hdr: 8'd2,  stall: 3, seed: 8'h00, ok: 1'b1};
      vecs[2] = '{hdr: 8'd0,  stall: 0, seed: 8'h00, ok: 1'b0};
      vecs[3] = '{hdr: 8'd17, stall: 0, seed: 8'h00, ok: 1'b0};
      vecs[4] = '{hdr: 8'd16, stall: 0, seed: 8'hA1, ok: 1'b1};
      vecs[5] = '{hdr: 8'd1,  stall: 1, seed: 8'h7C, ok: 1'b1};

      sys_rst_n  = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_waddr", 32'(mem_waddr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      sys_rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_load(vecs[i]);
         repeat (2) @(negedge clk);
      end

      // Timeout: header 1, two data bytes, then silence.
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (7) @(negedge clk);
      check("to_err_early", 32'(err), 32'd0);
      check("to_busy_early", 32'(busy), 32'd1);
      @(negedge clk);
      check("to_err", 32'(err), 32'd1);
      check("to_in_ready", 32'(in_ready), 32'd0);
      check("to_cpu_rst", 32'(cpu_rst), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // Reset in the middle of a load, after 5 data bytes.
      pulse_start();
      send_byte(8'h02);
      for (int b = 0; b < 5; b++) begin
         if (b == 3) sb_q.push_back('{addr: AW'(0), data: 32'hDEADBEEF});
         send_byte(8'(32'hDEADBEEF >> (24 - 8*b)));
      end
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_mem_we", 32'(mem_we), 32'd0);
      check("mid_rst_waddr", 32'(mem_waddr), 32'd0);
      check("mid_rst_wdata", mem_wdata, 32'd0);
      check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      sys_rst_n = 1'b1;
      @(negedge clk);
      v = '{hdr: 8'd1, stall: 0, seed: 8'h33, ok: 1'b1};
      do_load(v);

      // Reload straight after DONE: HDR outputs are checked in pulse_start,
      // and the scoreboard checks the overwrite of address 0.
      v = '{hdr: 8'd1, stall: 0, seed: 8'h44, ok: 1'b1};
      do_load(v);

      repeat (3) @(negedge clk);
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
